regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the RISC core, next generation of the single-write/dual-read file. It supports NRD read ports and NWR write ports, optional write-to-read bypass, an asynchronous clear to zero, and a per-register busy scoreboard for the issue/writeback stages. The block sits between decode (read and issue) and writeback (write and clear).

## Interface
- RFW, 5: register address width; depth is 2**RFW.
- DW, 32: data width.
- NRD, 2: number of read ports, 1..4.
- NWR, 1: number of write ports, 1..2.
- BYPASS, 1: 1 means a same-cycle write is visible on the read data; 0 means reads return stored contents only.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*RFW  read addresses; port k is bits [k*RFW +: RFW].
- rd_data  out  NRD*DW  read data, combinational from rd_addr.
- rd_busy  out  NRD  scoreboard busy bit of each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*RFW  write addresses.
- wr_data  in  NWR*DW  write data.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  RFW  destination register of the issued instruction.
- wb_clr  in  NWR  writeback completion per write port: clear busy for wr_addr of that port.
- busy_cnt  out  RFW+1  number of busy registers, registered.

## Operation
- Register 0:
  - Reads always return 0 and busy 0.
  - Writes, issue and clear to it are ignored.
- Write:
  - On a rising edge with wr_en[j]=1 and wr_addr[j]!=0, the register takes wr_data[j].
  - If both ports hit the same address in the same cycle, the higher port index wins.
- Read:
  - rd_data[k] is mem[rd_addr[k]].
  - With BYPASS=1, a same-cycle wr_en match on rd_addr[k] forwards that wr_data, with the highest matching write port winning.
  - With BYPASS=0, the old value is returned until the edge.
- Scoreboard: one busy bit per register.
  - iss_en sets busy[iss_addr].
  - wb_clr[j] clears busy[wr_addr[j]]. wb_clr is legal without wr_en.
  - If a set and a clear hit the same register in the same cycle, the set wins (a new producer supersedes the old).
  - A clear on a non-busy register is a no-op.
- rd_busy[k]:
  - Reflects the registered busy bit, not a same-cycle issue.
  - With BYPASS=1, a same-cycle wb_clr on that address forces rd_busy[k] to 0, unless iss_en targets the same address.
- busy_cnt: popcount of the busy bits after each edge. It is maintained incrementally (+1 per set of an idle register, −1 per effective clear) and never exceeds 2**RFW−1.

## Timing
- Reset (rst_n=0, asynchronous):
  - All registers are 0, all busy bits 0, busy_cnt 0.
  - rd_data reads 0 and rd_busy reads 0 while reset is asserted.
  - Inputs are ignored until the first rising edge after rst_n rises.
- Write latency:
  - 0 cycles to rd_data with BYPASS=1.
  - 1 cycle with BYPASS=0; the data is visible after the edge.
- Scoreboard latency:
  - Issue to rd_busy is 1 edge.
  - Clear to rd_busy is 0 cycles with BYPASS=1, 1 edge with BYPASS=0.
- Reset asserted mid-operation discards all pending writes, busy bits and the counter. There is no partial state.
- Timing path: the read path is purely combinational (address mux plus bypass compare). No internal delay annotations.

## Structure
- Package rf_pkg holds:
  - the defaults RFW_DEF=5, DW_DEF=32;
  - the function popcount-free increment/decrement helper;
  - the rf_addr_t/rf_data_t typedefs sized from the defaults.
- Sub-module rf_scoreboard (busy bits, set/clear priority, busy_cnt) is instantiated once.
- The data array and bypass muxes live in regfile_mp.

## Test plan
- Reset: assert rst_n=0 mid-run after writing r7=0x12345678 -> r7 reads 0, busy_cnt=0, rd_busy=0, immediately and asynchronously.
- Bypass: BYPASS=1, write r5=0xDEADBEEF on port 0 while rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF in the same cycle. With BYPASS=0 -> the old value, then 0xDEADBEEF after the edge.
- Register 0: write r0=0xFFFFFFFF, issue r0 -> r0 reads 0, rd_busy 0, busy_cnt unchanged.
- Write conflict: NWR=2, port 0 writes r9=0x1, port 1 writes r9=0x2 in the same cycle -> r9=0x2.
- Scoreboard: issue r3 -> rd_busy=1 and busy_cnt=1 after the edge.
  - Then wb_clr[0] with wr_addr[0]=3 and iss_en=1, iss_addr=3 in the same cycle -> r3 stays busy, busy_cnt=1.
  - Then a clear alone -> busy_cnt=0.
- Saturation: issue r1..r31 on consecutive cycles -> busy_cnt=31. Re-issuing a busy register -> busy_cnt stays 31.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, types and counter helper for the multi-port register file
package rf_pkg;

    localparam int RFW_DEF = 5;
    localparam int DW_DEF  = 32;

    typedef logic [RFW_DEF-1:0] rf_addr_t;
    typedef logic [DW_DEF-1:0]  rf_data_t;

    // Applies one cycle of increments/decrements to an occupancy count, clamped to [0, max].
    function automatic int unsigned cnt_step(input int unsigned cnt,
                                             input int unsigned inc,
                                             input int unsigned dec,
                                             input int unsigned max);
        int unsigned nxt;
        if (dec > cnt + inc) begin
            nxt = 0;
        end else begin
            nxt = cnt + inc - dec;
        end
        if (nxt > max) begin
            nxt = max;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with set-over-clear priority and running busy count
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int RFW = RFW_DEF,
    parameter int NWR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_en,
    input  logic [RFW-1:0]        iss_addr,
    input  logic [NWR-1:0]        wb_clr,
    input  logic [NWR*RFW-1:0]    wr_addr,
    output logic [(2**RFW)-1:0]   busy,
    output logic [RFW:0]          busy_cnt
);

    localparam int DEPTH = 2**RFW;
    localparam int CW    = RFW + 1;

    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_nxt;
    logic [RFW:0]     cnt_nxt;
    int unsigned      inc_n;
    int unsigned      dec_n;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        inc_n   = 0;
        dec_n   = 0;
        if (iss_en && (iss_addr != '0)) begin
            set_vec[iss_addr] = 1'b1;
            if (!busy[iss_addr]) begin
                inc_n = 1;
            end
        end
        for (int j = 0; j < NWR; j++) begin
            logic eff;
            eff = wb_clr[j] && (wr_addr[j*RFW +: RFW] != '0);
            if (eff) begin
                clr_vec[wr_addr[j*RFW +: RFW]] = 1'b1;
            end
            // Only a clear that actually drops a busy bit counts, and two ports
            // clearing the same register count once.
            if (!busy[wr_addr[j*RFW +: RFW]] || set_vec[wr_addr[j*RFW +: RFW]]) begin
                eff = 1'b0;
            end
            for (int k = 0; k < j; k++) begin
                if (wb_clr[k] && (wr_addr[k*RFW +: RFW] == wr_addr[j*RFW +: RFW])) begin
                    eff = 1'b0;
                end
            end
            if (eff) begin
                dec_n = dec_n + 1;
            end
        end
        busy_nxt = (busy & ~clr_vec) | set_vec;
        cnt_nxt  = CW'(cnt_step(32'(busy_cnt), inc_n, dec_n, DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with optional write bypass and busy scoreboard
module regfile_mp
    import rf_pkg::*;
#(
    parameter int RFW    = RFW_DEF,
    parameter int DW     = DW_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*RFW-1:0]  rd_addr,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*RFW-1:0]  wr_addr,
    input  logic [NWR*DW-1:0]   wr_data,
    input  logic                iss_en,
    input  logic [RFW-1:0]      iss_addr,
    input  logic [NWR-1:0]      wb_clr,
    output logic [RFW:0]        busy_cnt
);

    localparam int DEPTH = 2**RFW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;

    // Ascending port order: the highest-index writer to an address lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*RFW +: RFW] != '0)) begin
                    mem[wr_addr[j*RFW +: RFW]] <= wr_data[j*DW +: DW];
                end
            end
        end
    end

    rf_scoreboard #(
        .RFW (RFW),
        .NWR (NWR)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wb_clr   (wb_clr),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RFW-1:0] ra;
        logic [DW-1:0]  d;
        logic           bz;

        assign ra = rd_addr[k*RFW +: RFW];

        always_comb begin
            d  = mem[ra];
            bz = busy[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j*RFW +: RFW] == ra)) begin
                        d = wr_data[j*DW +: DW];
                    end
                    // A completing producer frees the register this cycle unless a new one claims it.
                    if (wb_clr[j] && (wr_addr[j*RFW +: RFW] == ra) &&
                        !(iss_en && (iss_addr == ra))) begin
                        bz = 1'b0;
                    end
                end
            end
            if ((ra == '0) || !rst_n) begin
                d  = '0;
                bz = 1'b0;
            end
        end

        assign rd_data[k*DW +: DW] = d;
        assign rd_busy[k]          = bz;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp, bypass and non-bypass builds side by side
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [1:0]  wb_clr;
    logic [5:0]  busy_cnt, busy_cnt_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.RFW(5), .DW(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .wb_clr(wb_clr), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.RFW(5), .DW(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .wb_clr(wb_clr), .busy_cnt(busy_cnt_nb)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        ie;
        logic [4:0]  ia;
        logic [1:0]  clr;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_bz0;
        logic [31:0] e_d0_nb;
        logic        e_bz0_nb;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; wb_clr = 2'b00; rd_addr = '0;
    endtask

    task automatic drive(input vec_t v);
        wr_en    = v.we;
        wr_addr  = {v.wa1, v.wa0};
        wr_data  = {v.wd1, v.wd0};
        rd_addr  = {v.ra1, v.ra0};
        iss_en   = v.ie;
        iss_addr = v.ia;
        wb_clr   = v.clr;
    endtask

    initial begin
        //        we     wa0   wd0           wa1   wd1           ra0   ra1   ie    ia    clr    e_d0          e_d1          bz0   e_d0_nb       bz_nb cnt
        vt[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 2'b00, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
        vt[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
        vt[2]  = '{2'b11, 5'd9, 32'h1,        5'd9, 32'h2,        5'd9, 5'd5, 1'b0, 5'd0, 2'b00, 32'h2,        32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 6'd0};
        vt[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd9, 5'd0, 1'b0, 5'd0, 2'b00, 32'h2,        32'h0,        1'b0, 32'h2,        1'b0, 6'd0};
        vt[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
        vt[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd3, 5'd0, 1'b1, 5'd3, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 6'd1};
        vt[6]  = '{2'b00, 5'd3, 32'h0,        5'd0, 32'h0,        5'd3, 5'd0, 1'b1, 5'd3, 2'b01, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 6'd1};
        vt[7]  = '{2'b00, 5'd3, 32'h0,        5'd0, 32'h0,        5'd3, 5'd0, 1'b0, 5'd0, 2'b01, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 6'd0};
        vt[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd3, 5'd0, 1'b0, 5'd0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
        vt[9]  = '{2'b00, 5'd0, 32'h0,        5'd4, 32'h0,        5'd4, 5'd0, 1'b1, 5'd4, 2'b10, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 6'd1};
        vt[10] = '{2'b00, 5'd4, 32'h0,        5'd4, 32'h0,        5'd4, 5'd0, 1'b0, 5'd0, 2'b11, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 6'd0};
        vt[11] = '{2'b11, 5'd6, 32'hA5A5A5A5, 5'd7, 32'h12345678, 5'd7, 5'd6, 1'b0, 5'd0, 2'b00, 32'h12345678, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 6'd0};
        vt[12] = '{2'b00, 5'd8, 32'h0,        5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 5'd0, 2'b01, 32'h12345678, 32'h0,        1'b0, 32'h12345678, 1'b0, 6'd0};

        rst_n = 1'b0;
        idle();
        rd_addr = {5'd0, 5'd3};
        #2;
        chk("reset_cnt", {58'd0, busy_cnt}, 64'd0);
        chk("reset_rd", rd_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d_d0", i), {32'd0, rd_data[31:0]}, {32'd0, vt[i].e_d0});
            chk($sformatf("v%0d_d1", i), {32'd0, rd_data[63:32]}, {32'd0, vt[i].e_d1});
            chk($sformatf("v%0d_bz0", i), {63'd0, rd_busy[0]}, {63'd0, vt[i].e_bz0});
            chk($sformatf("v%0d_d0_nb", i), {32'd0, rd_data_nb[31:0]}, {32'd0, vt[i].e_d0_nb});
            chk($sformatf("v%0d_bz0_nb", i), {63'd0, rd_busy_nb[0]}, {63'd0, vt[i].e_bz0_nb});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i), {58'd0, busy_cnt}, {58'd0, vt[i].e_cnt});
            chk($sformatf("v%0d_cnt_nb", i), {58'd0, busy_cnt_nb}, {58'd0, vt[i].e_cnt});
        end

        // Fill every register's busy bit, then re-issue one that is already busy.
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            idle();
            iss_en = 1'b1;
            iss_addr = 5'(r);
        end
        @(negedge clk);
        idle();
        rd_addr = {5'd0, 5'd31};
        #1;
        chk("sat_cnt", {58'd0, busy_cnt}, 64'd31);
        chk("sat_cnt_nb", {58'd0, busy_cnt_nb}, 64'd31);
        chk("sat_bz31", {63'd0, rd_busy[0]}, 64'd1);
        iss_en = 1'b1;
        iss_addr = 5'd5;
        @(posedge clk);
        #1;
        chk("reissue_cnt", {58'd0, busy_cnt}, 64'd31);
        @(negedge clk);
        idle();
        wb_clr = 2'b01;
        wr_addr = {5'd0, 5'd5};
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("clr5_bz", {63'd0, rd_busy[0]}, 64'd0);
        chk("clr5_bz_nb", {63'd0, rd_busy_nb[0]}, 64'd1);
        @(posedge clk);
        #1;
        chk("clr5_cnt", {58'd0, busy_cnt}, 64'd30);

        // Asynchronous reset between edges with r7 holding data and r7 busy.
        @(negedge clk);
        idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        chk("pre_rst_d7", {32'd0, rd_data[31:0]}, 64'h12345678);
        chk("pre_rst_bz7", {63'd0, rd_busy[0]}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_d7", {32'd0, rd_data[31:0]}, 64'd0);
        chk("rst_d7_nb", {32'd0, rd_data_nb[31:0]}, 64'd0);
        chk("rst_bz7", {63'd0, rd_busy[0]}, 64'd0);
        chk("rst_cnt", {58'd0, busy_cnt}, 64'd0);
        chk("rst_cnt_nb", {58'd0, busy_cnt_nb}, 64'd0);
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'd0, 32'hCAFEF00D};
        #1;
        chk("rst_bypass_d7", {32'd0, rd_data[31:0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 2'b00;
        @(posedge clk);
        #1;
        chk("post_rst_d7", {32'd0, rd_data[31:0]}, 64'd0);
        chk("post_rst_cnt", {58'd0, busy_cnt}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
